// File: rtl/bp_pkg.sv
// Shared branch-prediction types: history width, checkpoint depth,
// branch tag and checkpoint entry layout.
package bp_pkg;

    localparam int GHR_SIZE = 9;
    localparam int DEPTH    = 8;
    localparam int TAG_W    = $clog2(DEPTH);

    typedef logic [TAG_W-1:0] branch_tag_t;

    typedef struct packed {
        logic [GHR_SIZE-1:0] snap;
        logic                valid;
        logic                resolved;
    } ckpt_entry_t;

endpackage

// File: rtl/ghr_checkpoint_queue.sv
// Circular checkpoint buffer for the global history register.
// Fetch allocates one checkpoint per predicted branch (tag = tail index).
// The branch unit resolves out of order by tag. A mispredict replays the
// stored history to the GHR one cycle later and squashes younger entries.
module ghr_checkpoint_queue #(
    parameter int GHR_SIZE = bp_pkg::GHR_SIZE,
    parameter int DEPTH    = bp_pkg::DEPTH,
    parameter int TAG_W    = $clog2(DEPTH)
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                pred_branch1,
    input  logic                pred_branch2,
    input  logic [GHR_SIZE-1:0] prev_ghr,
    output logic                alloc_ready,
    output logic [TAG_W-1:0]    alloc_tag,
    input  logic                resolve_valid,
    input  logic [TAG_W-1:0]    resolve_tag,
    input  logic                resolve_taken,
    input  logic                resolve_mispredict,
    input  logic                flush,
    output logic                restore_ghr,
    output logic [GHR_SIZE-1:0] ghr_snap,
    output logic                actual_taken,
    output logic [TAG_W:0]      count
);

    typedef logic [TAG_W:0] ptr_t;

    typedef struct packed {
        logic [GHR_SIZE-1:0] snap;
        logic                valid;
        logic                resolved;
    } entry_t;

    entry_t entries [DEPTH];
    ptr_t   head;
    ptr_t   tail;

    // Advance a wrap-bit pointer by one slot.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return p + ptr_t'(1);
    endfunction

    // Distance from index a forward to index b, modulo DEPTH.
    function automatic logic [TAG_W-1:0] idx_dist(input logic [TAG_W-1:0] a,
                                                  input logic [TAG_W-1:0] b);
        return b - a;
    endfunction

    // Full pointer (with wrap bit) of an in-flight tag, relative to head.
    function automatic ptr_t ptr_of_tag(input ptr_t h, input logic [TAG_W-1:0] tag);
        return h + ptr_t'(idx_dist(h[TAG_W-1:0], tag));
    endfunction

    logic [TAG_W-1:0] head_idx;
    logic [TAG_W-1:0] tail_idx;
    logic             full;
    logic             alloc_req;
    logic             tag_valid;
    logic             mispredict_hit;
    logic             correct_hit;
    logic             retire_en;
    logic             alloc_fire;
    logic [TAG_W-1:0] squash_dist;
    ptr_t             squash_ptr;
    logic [DEPTH-1:0] squash_mask;

    // Allocation handshake: alloc_req (either slot predicting a branch) is a
    // request that must be held until accepted; alloc_ready depends only on
    // the registered queue state, and a checkpoint is written on the clock
    // edge where both are high, unless a mispredict or flush redirects fetch.
    assign head_idx    = head[TAG_W-1:0];
    assign tail_idx    = tail[TAG_W-1:0];
    assign full        = (head_idx == tail_idx) && (head[TAG_W] != tail[TAG_W]);
    assign count       = tail - head;
    assign alloc_ready = ~full;
    assign alloc_tag   = tail_idx;
    assign alloc_req   = pred_branch1 | pred_branch2;

    assign tag_valid      = entries[resolve_tag].valid;
    assign mispredict_hit = resolve_valid & resolve_mispredict & tag_valid;
    assign correct_hit    = resolve_valid & ~resolve_mispredict & tag_valid;
    assign retire_en      = entries[head_idx].valid & entries[head_idx].resolved;
    assign alloc_fire     = alloc_req & ~full & ~mispredict_hit & ~flush;

    assign squash_dist = idx_dist(head_idx, resolve_tag);
    assign squash_ptr  = ptr_of_tag(head, resolve_tag);

    // Mark every occupied slot that is younger than the mispredicted tag.
    always_comb begin
        squash_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (({1'b0, idx_dist(head_idx, TAG_W'(i))} > {1'b0, squash_dist}) &&
                ({1'b0, idx_dist(head_idx, TAG_W'(i))} < count)) begin
                squash_mask[i] = 1'b1;
            end
        end
    end

    // Checkpoint storage: allocate, resolve, squash and retire updates.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].valid    <= 1'b0;
                entries[i].resolved <= 1'b0;
            end
        end else begin
            if (correct_hit || mispredict_hit) entries[resolve_tag].resolved <= 1'b1;
            if (mispredict_hit) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (squash_mask[i]) entries[i].valid <= 1'b0;
                end
            end
            if (retire_en) entries[head_idx].valid <= 1'b0;
            if (alloc_fire) entries[tail_idx] <= '{snap: prev_ghr, valid: 1'b1, resolved: 1'b0};
        end
    end

    // Head/tail pointers: flush empties, mispredict truncates, alloc appends.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            head <= '0;
            tail <= '0;
        end else if (flush) begin
            head <= tail;
        end else begin
            if (retire_en) head <= ptr_inc(head);
            if (mispredict_hit)  tail <= ptr_inc(squash_ptr);
            else if (alloc_fire) tail <= ptr_inc(tail);
        end
    end

    // One-cycle registered restore pulse carrying the checkpointed history.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            restore_ghr  <= 1'b0;
            ghr_snap     <= '0;
            actual_taken <= 1'b0;
        end else if (flush) begin
            restore_ghr <= 1'b0;
        end else if (mispredict_hit) begin
            restore_ghr  <= 1'b1;
            ghr_snap     <= entries[resolve_tag].snap;
            actual_taken <= resolve_taken;
        end else begin
            restore_ghr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ghr_checkpoint_queue.sv
// Bench for ghr_checkpoint_queue: directed scenarios followed by random
// traffic, checked against an in-order list model of in-flight branches.
module tb_ghr_checkpoint_queue;
    import bp_pkg::*;

    localparam int GW = GHR_SIZE;
    localparam int DP = DEPTH;
    localparam int TW = TAG_W;

    logic          CLK;
    logic          reset;
    logic          pred_branch1, pred_branch2;
    logic [GW-1:0] prev_ghr;
    logic          alloc_ready;
    logic [TW-1:0] alloc_tag;
    logic          resolve_valid;
    logic [TW-1:0] resolve_tag;
    logic          resolve_taken, resolve_mispredict;
    logic          flush;
    logic          restore_ghr;
    logic [GW-1:0] ghr_snap;
    logic          actual_taken;
    logic [TW:0]   count;

    ghr_checkpoint_queue #(.GHR_SIZE(GW), .DEPTH(DP), .TAG_W(TW)) dut (
        .CLK(CLK), .reset(reset),
        .pred_branch1(pred_branch1), .pred_branch2(pred_branch2),
        .prev_ghr(prev_ghr), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .resolve_valid(resolve_valid), .resolve_tag(resolve_tag),
        .resolve_taken(resolve_taken), .resolve_mispredict(resolve_mispredict),
        .flush(flush), .restore_ghr(restore_ghr), .ghr_snap(ghr_snap),
        .actual_taken(actual_taken), .count(count)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    typedef struct {
        int            tag;
        logic [GW-1:0] snap;
        bit            res;
    } mdl_t;

    mdl_t          m_q[$];      // in-flight branches, oldest first
    int            m_tail;      // tag the next allocation receives
    logic [GW:0]   exp_q[$];    // expected restores {taken, snap}
    int            checks = 0;
    int            errors = 0;
    bit            mon_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock of branch-queue behaviour, applied at the sampling edge.
    task automatic model_step(input bit p1, input bit p2, input logic [GW-1:0] ghr,
                              input bit rv, input int rtag, input bit rtk,
                              input bit rmis, input bit fl);
        bit retire_f;
        bit mis_f;
        int idx;
        int sz0;
        retire_f = (m_q.size() > 0) && m_q[0].res;
        sz0 = m_q.size();
        idx = -1;
        if (rv) begin
            for (int i = 0; i < m_q.size(); i++) if (m_q[i].tag == rtag) idx = i;
        end
        mis_f = rv && rmis && (idx >= 0);
        if (fl) begin
            m_q.delete();
        end else begin
            if (idx >= 0) begin
                m_q[idx].res = 1;
                if (rmis) begin
                    exp_q.push_back({rtk, m_q[idx].snap});
                    while (m_q.size() > idx + 1) void'(m_q.pop_back());
                    m_tail = (rtag + 1) % DP;
                end
            end
            if (retire_f) void'(m_q.pop_front());
            if ((p1 || p2) && (sz0 < DP) && !mis_f) begin
                m_q.push_back('{tag: m_tail, snap: ghr, res: 1'b0});
                m_tail = (m_tail + 1) % DP;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle(input bit p1, input bit p2, input logic [GW-1:0] ghr,
                         input bit rv, input int rtag, input bit rtk,
                         input bit rmis, input bit fl);
        @(negedge CLK);
        #1;
        pred_branch1       = p1;
        pred_branch2       = p2;
        prev_ghr           = ghr;
        resolve_valid      = rv;
        resolve_tag        = TW'(rtag);
        resolve_taken      = rtk;
        resolve_mispredict = rmis;
        flush              = fl;
        @(posedge CLK);
        if (reset) model_step(p1, p2, ghr, rv, rtag, rtk, rmis, fl);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, 0, '0, 0, 0, 0, 0, 0);
    endtask

    task automatic alloc(input logic [GW-1:0] ghr);
        cycle(1, 0, ghr, 0, 0, 0, 0, 0);
    endtask

    task automatic resolve(input int tag, input bit tk, input bit mis);
        cycle(0, 0, '0, 1, tag, tk, mis, 0);
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        #1;
        reset = 1'b0;
        pred_branch1 = 0; pred_branch2 = 0; prev_ghr = '0;
        resolve_valid = 0; resolve_tag = '0; resolve_taken = 0;
        resolve_mispredict = 0; flush = 0;
        m_q.delete();
        m_tail = 0;
        exp_q.delete();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("reset_restore", restore_ghr, 0);
        check("reset_snap", ghr_snap, 0);
        check("reset_taken", actual_taken, 0);
        check("reset_count", count, 0);
        check("reset_ready", alloc_ready, 1);
        #1;
        reset = 1'b1;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge CLK) begin
        if (mon_en) begin
            check("count", count, m_q.size());
            check("alloc_ready", alloc_ready, (m_q.size() < DP) ? 1 : 0);
            check("alloc_tag", alloc_tag, m_tail);
            if (restore_ghr) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL restore_unexpected: got restore_ghr=1 expected 0 at %0t", $time);
                end else begin
                    logic [GW:0] e;
                    e = exp_q.pop_front();
                    check("ghr_snap", ghr_snap, e[GW-1:0]);
                    check("actual_taken", actual_taken, e[GW]);
                end
            end else if (exp_q.size() > 0) begin
                checks++;
                errors++;
                $display("FAIL restore_missing: got restore_ghr=0 expected 1 at %0t", $time);
                exp_q.delete();
            end
        end
    end

    // ---------------- stimulus ----------------
    int t0, t1, t2, r_tag;
    bit r_p1, r_p2, r_rv, r_mis, r_fl;

    initial begin
        reset = 1'b0;
        pred_branch1 = 0; pred_branch2 = 0; prev_ghr = '0;
        resolve_valid = 0; resolve_tag = '0; resolve_taken = 0;
        resolve_mispredict = 0; flush = 0;
        apply_reset();
        mon_en = 1;

        // three allocations, then mispredict the middle one
        alloc(9'h001);
        alloc(9'h003);
        alloc(9'h007);
        resolve(1, 1, 1);
        resolve(0, 0, 0);
        idle(4);

        // fill to capacity, hold a ninth request, free one slot
        for (int i = 0; i < DP; i++) cycle(0, 1, GW'($urandom), 0, 0, 0, 0, 0);
        cycle(1, 0, 9'h0AA, 0, 0, 0, 0, 0);
        cycle(1, 0, 9'h0AA, 1, m_q[0].tag, 0, 0, 0);
        cycle(1, 0, 9'h0AA, 0, 0, 0, 0, 0);
        cycle(1, 0, 9'h0AA, 0, 0, 0, 0, 0);

        // out-of-order correct resolves: head moves only once the oldest resolves
        t0 = m_q[0].tag; t1 = m_q[1].tag; t2 = m_q[2].tag;
        resolve(t2, 1, 0);
        resolve(t1, 0, 0);
        resolve(t0, 1, 0);
        idle(4);
        cycle(0, 0, '0, 0, 0, 0, 0, 1);
        idle(1);

        // wrap-around squash: head at 6, tags 6,7,0,1, mispredict tag 7
        apply_reset();
        for (int i = 0; i < 6; i++) alloc(GW'($urandom));
        for (int i = 0; i < 6; i++) resolve(i, 0, 0);
        idle(3);
        alloc(9'h1A6);
        alloc(9'h0B7);
        alloc(9'h150);
        alloc(9'h0E1);
        resolve(7, 0, 1);
        idle(1);
        resolve(0, 1, 1);
        resolve(1, 1, 1);
        idle(2);

        // mispredict with same-cycle alloc, flush with pending mispredict
        alloc(9'h011);
        alloc(9'h022);
        cycle(1, 0, 9'h033, 1, m_q[0].tag, 1, 1, 0);
        idle(1);
        alloc(9'h044);
        alloc(9'h055);
        cycle(0, 0, '0, 1, m_q[1].tag, 0, 1, 1);
        idle(2);
        alloc(9'h066);
        alloc(9'h077);
        alloc(9'h088);
        apply_reset();
        idle(2);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            r_p1  = ($urandom_range(0, 2) == 0);
            r_p2  = ($urandom_range(0, 3) == 0);
            r_rv  = ($urandom_range(0, 9) < 4);
            r_mis = ($urandom_range(0, 9) == 0);
            r_fl  = ($urandom_range(0, 99) == 0);
            if ((m_q.size() > 0) && ($urandom_range(0, 3) != 0))
                r_tag = m_q[$urandom_range(0, m_q.size() - 1)].tag;
            else
                r_tag = $urandom_range(0, DP - 1);
            if ($urandom_range(0, 499) == 0) apply_reset();
            else cycle(r_p1, r_p2, GW'($urandom), r_rv, r_tag, $urandom_range(0, 1), r_mis, r_fl);
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
